fifo_wconv_sc: RTL

Single-clock FIFO with write-to-read width conversion. It is the parametrised successor to the team's 8-in/16-out FIFO: write width, read/write width ratio, depth and almost-full/almost-empty thresholds are all configurable. It adds a read-valid strobe, sticky-free overflow/underflow pulses and programmable almost flags. It sits between a byte-oriented producer and a wider consumer in the same clock domain.

---
 rtl/fifo_wconv_sc.sv | 113 +++++++++++
 1 files changed

// File: rtl/fifo_wconv_sc.sv
// Single-clock FIFO that stores narrow write words and pops RATIO of them per read,
// packed LSB-first into one wide read word. Flags are registered from the post-edge count.
module fifo_wconv_sc #(
  parameter  int WR_WIDTH  = 8,
  parameter  int RATIO     = 2,
  parameter  int DEPTH     = 256,
  parameter  int AFULL_TH  = 240,
  parameter  int AEMPTY_TH = 2,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      wr_req,
  input  logic [WR_WIDTH-1:0]       wr_data,
  input  logic                      rd_req,
  output logic [WR_WIDTH*RATIO-1:0] rd_data,
  output logic                      rd_valid,
  output logic                      wr_full,
  output logic [AW:0]               wr_usedw,
  output logic                      rd_empty,
  output logic [AW:0]               rd_usedw,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int          LOG2R     = $clog2(RATIO);
  localparam logic [AW:0] C_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_RATIO   = (AW+1)'(RATIO);
  localparam logic [AW:0] C_AFULL   = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] C_AEMPTY  = (AW+1)'(AEMPTY_TH);
  localparam logic [AW-1:0] C_PTR_STEP = AW'(RATIO);

  logic [WR_WIDTH-1:0]       r_mem [DEPTH];
  logic [AW-1:0]             r_wr_ptr;
  logic [AW-1:0]             r_rd_ptr;
  logic [AW:0]               r_count;
  logic                      r_full;
  logic                      r_empty;
  logic                      r_afull;
  logic                      r_aempty;
  logic                      r_ovf;
  logic                      r_udf;
  logic                      r_rd_valid;
  logic [WR_WIDTH*RATIO-1:0] r_rd_data;

  logic                      w_wr_acc;
  logic                      w_rd_acc;
  logic [AW:0]               w_count_nxt;
  logic [AW:0]               w_rd_usedw_nxt;
  logic [WR_WIDTH*RATIO-1:0] w_rd_word;

  // Acceptance uses the registered (pre-edge) flags only, so a concurrent
  // read never frees room for a write in the same cycle and vice versa.
  assign w_wr_acc       = wr_req & ~r_full;
  assign w_rd_acc       = rd_req & ~r_empty;
  assign w_count_nxt    = r_count + (AW+1)'(w_wr_acc) - (w_rd_acc ? C_RATIO : '0);
  assign w_rd_usedw_nxt = w_count_nxt >> LOG2R;

  always_comb begin
    w_rd_word = '0;
    for (int k = 0; k < RATIO; k++) begin
      w_rd_word[k*WR_WIDTH +: WR_WIDTH] = r_mem[r_rd_ptr + AW'(k)];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_afull    <= 1'b0;
      r_aempty   <= 1'b1;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) begin
        r_rd_ptr  <= r_rd_ptr + C_PTR_STEP;
        r_rd_data <= w_rd_word;
      end
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == C_DEPTH);
      r_empty    <= (w_rd_usedw_nxt == '0);
      r_afull    <= (w_count_nxt >= C_AFULL);
      r_aempty   <= (w_rd_usedw_nxt <= C_AEMPTY);
      r_ovf      <= wr_req & r_full;
      r_udf      <= rd_req & r_empty;
      r_rd_valid <= w_rd_acc;
    end
  end

  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign wr_full      = r_full;
  assign wr_usedw     = r_count;
  assign rd_empty     = r_empty;
  assign rd_usedw     = r_count >> LOG2R;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule
